// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//   Shared definitions for the shift_deserializer slice.
//   - hold_state_t : EMPTY/FULL encodings of the output holding register
//   - clog2()      : constant ceil(log2) helper, minimum result 1
//   - frame_len()  : serial frame length for a given data width
//   - PARITY_EN    : 1 when the even-parity frame option is compiled in
//
//   Optional feature macro: SHIFT_DESERIALIZER_PARITY_EN
//     defined   -> frame is WIDTH data bits followed by one even-parity bit
//     undefined -> frame is WIDTH data bits
// -----------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

`ifdef SHIFT_DESERIALIZER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // ceil(log2(value)); never returns less than 1 so a counter is always
  // at least one bit wide.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

  // Number of serial bits per word on the link.
  function automatic int frame_len(input int width);
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/shift_word_hold.sv
// -----------------------------------------------------------------------------
// shift_word_hold
//   One-word holding register between the bit assembler and a valid/ready
//   consumer.
//
//   Handshake: the word on o_data is offered while o_state == HOLD_FULL; it is
//   consumed on a rising edge where the holder is FULL and i_ready=1. o_data
//   and o_perr are stable while FULL and change only on clock edges.
//
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     i_load     : a completed word is offered this cycle
//     i_data     : completed word
//     i_perr     : parity error flag travelling with i_data
//     i_ready    : consumer accepts the presented word
//     o_data     : presented word (registered)
//     o_perr     : parity flag of the presented word (registered)
//     o_state    : holding FSM state; FULL means a word is presented
//     o_drop     : i_load arrived while FULL and not being emptied; the new
//                  word is discarded (combinational, used for overrun)
// -----------------------------------------------------------------------------
module shift_word_hold
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_perr,
  input  logic              i_ready,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_perr,
  output hold_state_t       o_state,
  output logic              o_drop
);

  hold_state_t      r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HOLD_EMPTY;
      r_data  <= '0;
      r_perr  <= 1'b0;
    end else begin
      case (r_state)
        HOLD_EMPTY: begin
          if (i_load) begin
            r_data  <= i_data;
            r_perr  <= i_perr;
            r_state <= HOLD_FULL;
          end
        end
        HOLD_FULL: begin
          if (i_ready && i_load) begin
            // Old word leaves and new one arrives on the same edge: no bubble.
            r_data  <= i_data;
            r_perr  <= i_perr;
          end else if (i_ready) begin
            // Data is left in place; it is simply no longer valid.
            r_state <= HOLD_EMPTY;
          end
          // i_load without i_ready: new word dropped, held word untouched.
        end
        default: r_state <= HOLD_EMPTY;
      endcase
    end
  end

  assign o_data  = r_data;
  assign o_perr  = r_perr;
  assign o_state = r_state;
  assign o_drop  = i_load && (r_state == HOLD_FULL) && !i_ready;

endmodule

// File: rtl/shift_deserializer.sv
// -----------------------------------------------------------------------------
// shift_deserializer
//   Serial-in parallel-out receiver. Samples SI (MSB first) on edges where
//   clken=1, assembles WIDTH-bit words and presents them through a one-word
//   holding register on a valid/ready port.
//
//   Handshake: out_data is valid while out_valid=1 and stays stable until a
//   rising edge with out_valid & out_ready, which consumes it. A word that
//   completes while the held word is not being consumed is dropped and sets
//   the sticky overrun flag.
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous active-low reset
//     clken        bit strobe; SI sampled only when 1
//     SI           serial data, MSB first
//     sync         frame restart, discards the partial word
//     out_data     assembled word
//     out_valid    word available
//     out_ready    consumer accepts
//     out_perr     parity error for presented word (0 without parity option)
//     overrun      sticky dropped-word flag
//     clr_overrun  synchronous clear of overrun (a simultaneous drop wins)
//
//   Optional feature macro: SHIFT_DESERIALIZER_PARITY_EN adds an even-parity
//   bit after the WIDTH data bits of each frame.
// -----------------------------------------------------------------------------
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic             SI,
  input  logic             sync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_perr,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int             FRAME = frame_len(WIDTH);
  localparam int             CW    = clog2(FRAME);
  localparam logic [CW-1:0]  LAST  = CW'(FRAME - 1);

  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bitcnt;
  logic             r_overrun;

  logic             w_last;
  logic             w_shift;
  logic [WIDTH-1:0] w_word;
  logic             w_perr;
  logic             w_drop;
  hold_state_t      w_state;

  // A sync on what would have been the final edge cancels the completion.
  assign w_last = clken && !sync && (r_bitcnt == LAST);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
  // The final bit of the frame is the parity bit: the data bits are already
  // in r_shreg, so the parity bit is only folded into the check, never shifted.
  assign w_shift = clken && !w_last;
  assign w_word  = r_shreg;
  assign w_perr  = (^r_shreg) ^ SI;
`else
  // The bit arriving on the completing edge is the word's LSB.
  assign w_shift = clken;
  assign w_word  = {r_shreg[WIDTH-2:0], SI};
  assign w_perr  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg  <= '0;
      r_bitcnt <= '0;
    end else if (sync) begin
      // Restart the frame; with a strobe on the same edge, SI is bit 0.
      if (clken) begin
        r_shreg  <= {{(WIDTH-1){1'b0}}, SI};
        r_bitcnt <= CW'(1);
      end else begin
        r_shreg  <= '0;
        r_bitcnt <= '0;
      end
    end else if (clken) begin
      if (w_shift) r_shreg <= {r_shreg[WIDTH-2:0], SI};
      if (w_last) r_bitcnt <= '0;
      else        r_bitcnt <= r_bitcnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  shift_word_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst),
    .i_load  (w_last),
    .i_data  (w_word),
    .i_perr  (w_perr),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_perr  (out_perr),
    .o_state (w_state),
    .o_drop  (w_drop)
  );

  assign out_valid = (w_state == HOLD_FULL);
  assign overrun   = r_overrun;

endmodule
